// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS front end: next-PC encodings,
// instruction field positions and handshake FSM states.
package mips_pkg;

    typedef enum logic [1:0] {
        PC_ALU    = 2'b00,
        PC_ALUOUT = 2'b01,
        PC_JUMP   = 2'b10,
        PC_HOLD   = 2'b11
    } pcsrc_e;

    typedef enum logic {
        HS_IDLE = 1'b0,
        HS_BUSY = 1'b1
    } hs_state_e;

    localparam int OP_MSB    = 31;
    localparam int OP_LSB    = 26;
    localparam int FUNCT_MSB = 5;
    localparam int FUNCT_LSB = 0;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // J-type target keeps the current 256MB region of the PC
    function automatic logic [31:0] jump_target(input logic [31:0] pc, input logic [31:0] instr);
        return {pc[31:28], instr[25:0], 2'b00};
    endfunction

endpackage

// File: rtl/mem_handshake.sv
// Memory access sequencer: tracks one outstanding request, counts wait states,
// freezes the controller via stall and aborts with bus_err after TIMEOUT cycles.
module mem_handshake
    import mips_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic req,
    input  logic mem_ready,
    output logic mem_req,
    output logic stall,
    output logic bus_err,
    output logic complete,
    output logic abort
);

    localparam logic [7:0] TO = 8'(TIMEOUT);

    hs_state_e  state;
    logic [7:0] cnt;
    logic [7:0] cnt_nxt;
    logic       pend;

    // Outputs are gated by reset so an access vanishes the moment reset asserts
    assign pend     = reset & ((state == HS_BUSY) | req);
    assign cnt_nxt  = (state == HS_BUSY) ? cnt + 8'd1 : 8'd1;
    assign abort    = pend & ~mem_ready & (cnt_nxt == TO);
    assign complete = pend & mem_ready;
    assign stall    = pend & ~mem_ready & ~abort;
    assign bus_err  = abort;
    assign mem_req  = pend;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= HS_IDLE;
            cnt   <= 8'd0;
        end else if (complete || abort) begin
            state <= HS_IDLE;
            cnt   <= 8'd0;
        end else if (pend) begin
            state <= HS_BUSY;
            cnt   <= cnt_nxt;
        end
    end

endmodule

// File: rtl/fetch_mem_unit.sv
// Multicycle MIPS front end: PC/IR/MDR registers, memory address mux and
// next-PC selection, with the memory handshake delegated to mem_handshake.
module fetch_mem_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pcen,
    input  logic [1:0]  pcsrc,
    input  logic        irwrite,
    input  logic        iord,
    input  logic        memrd,
    input  logic        memwrite,
    input  logic [31:0] aluresult,
    input  logic [31:0] aluout,
    input  logic [31:0] writedata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic [5:0]  op,
    output logic [5:0]  funct,
    output logic [31:0] data,
    output logic        stall,
    output logic        bus_err
);

    logic        complete;
    logic        abort;
    logic [31:0] next_pc;

    mem_handshake #(.TIMEOUT(TIMEOUT)) u_hs (
        .clk       (clk),
        .reset     (reset),
        .req       (irwrite | memrd | memwrite),
        .mem_ready (mem_ready),
        .mem_req   (mem_req),
        .stall     (stall),
        .bus_err   (bus_err),
        .complete  (complete),
        .abort     (abort)
    );

    assign mem_addr  = iord ? aluout : pc;
    assign mem_wdata = writedata;
    assign mem_we    = memwrite & mem_req;
    assign op        = instr[OP_MSB:OP_LSB];
    assign funct     = instr[FUNCT_MSB:FUNCT_LSB];

    always_comb begin
        next_pc = pc;
        case (pcsrc_e'(pcsrc))
            PC_ALU:    next_pc = aluresult;
            PC_ALUOUT: next_pc = aluout;
            PC_JUMP:   next_pc = jump_target(pc, instr);
            PC_HOLD:   next_pc = pc;
            default:   next_pc = pc;
        endcase
    end

    // PC only moves on a cycle the controller is actually allowed to advance
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc    <= RESET_PC;
            instr <= 32'd0;
            data  <= 32'd0;
        end else begin
            if (pcen && !stall && !abort)
                pc <= next_pc;
            if (complete && irwrite)
                instr <= mem_rdata;
            if (complete && (irwrite || memrd))
                data <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_mem_unit.sv
// Directed self-checking bench for fetch_mem_unit: fetch with and without wait
// states, loads/stores, next-PC selection, jumps, timeout abort and async reset.
module tb_fetch_mem_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pcen, irwrite, iord, memrd, memwrite, mem_ready;
    logic [1:0]  pcsrc;
    logic [31:0] aluresult, aluout, writedata, mem_rdata;
    logic [31:0] mem_addr, mem_wdata, pc, instr, data;
    logic        mem_req, mem_we, stall, bus_err;
    logic [5:0]  op, funct;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fetch_mem_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .pcen(pcen), .pcsrc(pcsrc), .irwrite(irwrite),
        .iord(iord), .memrd(memrd), .memwrite(memwrite), .aluresult(aluresult),
        .aluout(aluout), .writedata(writedata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_req(mem_req), .mem_we(mem_we), .pc(pc), .instr(instr), .op(op),
        .funct(funct), .data(data), .stall(stall), .bus_err(bus_err)
    );

    task automatic idle_inputs();
        pcen = 0; pcsrc = 2'b00; irwrite = 0; iord = 0; memrd = 0; memwrite = 0;
        mem_ready = 0; aluresult = 0; aluout = 0; writedata = 0; mem_rdata = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        #3 reset = 1'b0;
        #1;
        n_chk++; if (pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h exp %h", pc, 32'h0); end
        n_chk++; if (instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr got %h exp %h", instr, 32'h0); end
        n_chk++; if (data !== 32'h0) begin n_fail++; $display("FAIL reset_data got %h exp %h", data, 32'h0); end
        n_chk++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req got %b exp 0", mem_req); end
        n_chk++; if (stall !== 1'b0 || bus_err !== 1'b0 || mem_we !== 1'b0) begin
            n_fail++; $display("FAIL reset_ctl got stall=%b bus_err=%b we=%b exp 0", stall, bus_err, mem_we); end
        @(posedge clk); @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_zero_wait_fetch();
        @(negedge clk);
        idle_inputs();
        irwrite = 1; pcen = 1; pcsrc = 2'b00; aluresult = 32'h4; mem_ready = 1; mem_rdata = 32'h8C01_0004;
        #1;
        n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL zw_stall got %b exp 0", stall); end
        n_chk++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
            n_fail++; $display("FAIL zw_req got req=%b addr=%h exp 1/%h", mem_req, mem_addr, 32'h0); end
        @(posedge clk); #1;
        n_chk++; if (instr !== 32'h8C01_0004) begin n_fail++; $display("FAIL zw_instr got %h exp %h", instr, 32'h8C01_0004); end
        n_chk++; if (op !== 6'h23) begin n_fail++; $display("FAIL zw_op got %h exp %h", op, 6'h23); end
        n_chk++; if (pc !== 32'h4) begin n_fail++; $display("FAIL zw_pc got %h exp %h", pc, 32'h4); end
        n_chk++; if (data !== 32'h8C01_0004) begin n_fail++; $display("FAIL zw_data got %h exp %h", data, 32'h8C01_0004); end
    endtask

    task automatic test_wait_fetch();
        @(negedge clk);
        idle_inputs();
        irwrite = 1; pcen = 1; pcsrc = 2'b00; aluresult = 32'h8; mem_ready = 0; mem_rdata = 32'h0022_1820;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_chk++; if (stall !== 1'b1 || mem_addr !== 32'h4) begin
                n_fail++; $display("FAIL wait_stall[%0d] got stall=%b addr=%h exp 1/%h", i, stall, mem_addr, 32'h4); end
            @(posedge clk); #1;
            n_chk++; if (pc !== 32'h4 || instr !== 32'h8C01_0004) begin
                n_fail++; $display("FAIL wait_hold[%0d] got pc=%h instr=%h exp %h/%h", i, pc, instr, 32'h4, 32'h8C01_0004); end
            @(negedge clk);
        end
        mem_ready = 1;
        #1;
        n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL wait_done_stall got %b exp 0", stall); end
        @(posedge clk); #1;
        n_chk++; if (pc !== 32'h8) begin n_fail++; $display("FAIL wait_pc got %h exp %h", pc, 32'h8); end
        n_chk++; if (instr !== 32'h0022_1820 || funct !== 6'h20) begin
            n_fail++; $display("FAIL wait_instr got %h/%h exp %h/%h", instr, funct, 32'h0022_1820, 6'h20); end
    endtask

    task automatic test_memrw();
        @(negedge clk);
        idle_inputs();
        memwrite = 1; iord = 1; aluout = 32'h200; writedata = 32'hDEAD_BEEF; mem_ready = 1; mem_rdata = 32'h5555_5555;
        #1;
        n_chk++; if (mem_we !== 1'b1 || mem_addr !== 32'h200 || mem_wdata !== 32'hDEAD_BEEF || stall !== 1'b0) begin
            n_fail++; $display("FAIL sw_bus got we=%b addr=%h wd=%h stall=%b exp 1/%h/%h/0",
                               mem_we, mem_addr, mem_wdata, stall, 32'h200, 32'hDEAD_BEEF); end
        @(posedge clk); #1;
        n_chk++; if (data !== 32'h0022_1820) begin n_fail++; $display("FAIL sw_data got %h exp %h", data, 32'h0022_1820); end
        @(negedge clk);
        memwrite = 0; memrd = 1; mem_rdata = 32'h1234_5678;
        #1;
        n_chk++; if (mem_we !== 1'b0 || mem_req !== 1'b1) begin
            n_fail++; $display("FAIL lw_bus got we=%b req=%b exp 0/1", mem_we, mem_req); end
        @(posedge clk); #1;
        n_chk++; if (data !== 32'h1234_5678 || instr !== 32'h0022_1820 || pc !== 32'h8) begin
            n_fail++; $display("FAIL lw_regs got data=%h instr=%h pc=%h exp %h/%h/%h",
                               data, instr, pc, 32'h1234_5678, 32'h0022_1820, 32'h8); end
    endtask

    task automatic test_pcsrc();
        @(negedge clk);
        idle_inputs();
        pcen = 1; pcsrc = 2'b01; aluout = 32'h44; aluresult = 32'h99;
        @(posedge clk); #1;
        n_chk++; if (pc !== 32'h44) begin n_fail++; $display("FAIL pcsrc_aluout got %h exp %h", pc, 32'h44); end
        @(negedge clk);
        pcsrc = 2'b11;
        @(posedge clk); #1;
        n_chk++; if (pc !== 32'h44) begin n_fail++; $display("FAIL pcsrc_hold got %h exp %h", pc, 32'h44); end
        @(negedge clk);
        pcen = 0; pcsrc = 2'b00;
        @(posedge clk); #1;
        n_chk++; if (pc !== 32'h44) begin n_fail++; $display("FAIL pcen_low got %h exp %h", pc, 32'h44); end
    endtask

    task automatic test_jump();
        @(negedge clk);
        idle_inputs();
        irwrite = 1; pcen = 1; aluresult = 32'h0040_0010; mem_ready = 1; mem_rdata = 32'h0810_0004;
        @(negedge clk);
        idle_inputs();
        pcen = 1; pcsrc = 2'b10;
        @(posedge clk); #1;
        n_chk++; if (pc !== 32'h0040_0010) begin n_fail++; $display("FAIL jump_low got %h exp %h", pc, 32'h0040_0010); end
        @(negedge clk);
        idle_inputs();
        irwrite = 1; pcen = 1; aluresult = 32'h9000_0000; mem_ready = 1; mem_rdata = 32'h0800_0040;
        @(negedge clk);
        idle_inputs();
        pcen = 1; pcsrc = 2'b10;
        @(posedge clk); #1;
        n_chk++; if (pc !== 32'h9000_0100) begin n_fail++; $display("FAIL jump_region got %h exp %h", pc, 32'h9000_0100); end
    endtask

    task automatic test_timeout();
        @(negedge clk);
        idle_inputs();
        memrd = 1; iord = 1; aluout = 32'h100; mem_ready = 0; mem_rdata = 32'hFFFF_FFFF; pcen = 1; aluresult = 32'h777;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_chk++; if (mem_addr !== 32'h100 || bus_err !== (i == 3) || stall !== (i != 3)) begin
                n_fail++; $display("FAIL timeout[%0d] got addr=%h bus_err=%b stall=%b exp %h/%b/%b",
                                   i, mem_addr, bus_err, stall, 32'h100, (i == 3), (i != 3)); end
            @(posedge clk);
            @(negedge clk);
            if (i == 3) idle_inputs();
        end
        #1;
        n_chk++; if (data !== 32'h0800_0040 || pc !== 32'h9000_0100) begin
            n_fail++; $display("FAIL timeout_regs got data=%h pc=%h exp %h/%h", data, pc, 32'h0800_0040, 32'h9000_0100); end
        n_chk++; if (stall !== 1'b0 || bus_err !== 1'b0 || mem_req !== 1'b0) begin
            n_fail++; $display("FAIL timeout_after got stall=%b bus_err=%b req=%b exp 0/0/0", stall, bus_err, mem_req); end
    endtask

    task automatic test_reset_busy();
        @(negedge clk);
        idle_inputs();
        irwrite = 1; pcen = 1; aluresult = 32'h50; mem_ready = 0; mem_rdata = 32'hAAAA_AAAA;
        @(posedge clk); #1;
        n_chk++; if (stall !== 1'b1 || mem_req !== 1'b1) begin
            n_fail++; $display("FAIL rb_busy got stall=%b req=%b exp 1/1", stall, mem_req); end
        #2 reset = 1'b0;
        #1;
        n_chk++; if (mem_req !== 1'b0 || stall !== 1'b0 || pc !== 32'h0 || instr !== 32'h0) begin
            n_fail++; $display("FAIL rb_async got req=%b stall=%b pc=%h instr=%h exp 0/0/0/0", mem_req, stall, pc, instr); end
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
        @(posedge clk); #1;
        n_chk++; if (pc !== 32'h0 || mem_req !== 1'b0 || stall !== 1'b0 || data !== 32'h0) begin
            n_fail++; $display("FAIL rb_release got pc=%h req=%b stall=%b data=%h exp 0/0/0/0", pc, mem_req, stall, data); end
        @(negedge clk);
        memrd = 1; mem_ready = 1; mem_rdata = 32'h0BAD_F00D;
        @(posedge clk); #1;
        n_chk++; if (data !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL rb_idle_access got %h exp %h", data, 32'h0BAD_F00D); end
    endtask

    initial begin
        test_reset();
        test_zero_wait_fetch();
        test_wait_fetch();
        test_memrw();
        test_pcsrc();
        test_jump();
        test_timeout();
        test_reset_busy();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
